// File: rtl/puf_resp_packer_pkg.sv
// puf_pkg: shared types and constants for the RO-PUF response packer.
//
// Contents:
//   puf_state_e   - packer state (COLLECT while filling a word, HOLD while
//                   the finished word waits for the consumer)
//   PUF_CNT_W     - default oscillator count width, shared with the counters
//   PUF_RESP_W    - default response bits per word
//   puf_w()       - width helper for bit_idx and unstable_cnt
//
// Optional feature macro used by the files that import this package:
//   PUF_RELIAB_EN - enables the per-bit reliability mask and unstable count.

package puf_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } puf_state_e;

  localparam int PUF_CNT_W  = 8;
  localparam int PUF_RESP_W = 8;

  // Width of a counter that must represent values up to n-1.
  // Clamped to 1 so that a degenerate n still yields a legal vector.
  function automatic int puf_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/puf_resp_packer_if.sv
// puf_resp_packer_if: pair-in / word-out handshake bundle for the packer.
//
// Parameters: CNT_W (count width), RESP_W (bits per response word).
// Signals:
//   in_valid, in_ready, cnt_a, cnt_b   - count pair stream from the RO counters
//   resp_valid, resp_ready             - response word handshake
//   resp, resp_mask, unstable_cnt      - packed word, unreliable-bit mask, mask popcount
//   bit_idx                            - slot the next accepted pair will fill
// Modports:
//   master - the environment (counters upstream, key/ID consumer downstream)
//   slave  - the packer itself
//
// Macro: none here; PUF_RELIAB_EN only changes what the packer drives onto
// resp_mask and unstable_cnt, not the bundle.

interface puf_resp_packer_if
  import puf_pkg::*;
#(
  parameter int CNT_W  = PUF_CNT_W,
  parameter int RESP_W = PUF_RESP_W
);

  localparam int IDX_W = puf_w(RESP_W);
  localparam int UC_W  = puf_w(RESP_W + 1);

  logic              in_valid;
  logic              in_ready;
  logic [CNT_W-1:0]  cnt_a;
  logic [CNT_W-1:0]  cnt_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [RESP_W-1:0] resp;
  logic [RESP_W-1:0] resp_mask;
  logic [UC_W-1:0]   unstable_cnt;
  logic [IDX_W-1:0]  bit_idx;

  modport master (
    output in_valid, cnt_a, cnt_b, resp_ready,
    input  in_ready, resp_valid, resp, resp_mask, unstable_cnt, bit_idx
  );

  modport slave (
    input  in_valid, cnt_a, cnt_b, resp_ready,
    output in_ready, resp_valid, resp, resp_mask, unstable_cnt, bit_idx
  );

endinterface

// File: rtl/puf_resp_packer_cmp.sv
// puf_cnt_cmp: combinational comparator for one ring-oscillator count pair.
//
// Parameters: CNT_W (count width).
// Ports:
//   cnt_a, cnt_b - unsigned oscillator counts
//   gt           - 1 when cnt_a is strictly greater than cnt_b (ties give 0)
//   abs_diff     - |cnt_a - cnt_b| in CNT_W+1 bits, present only when
//                  PUF_RELIAB_EN is defined
//
// Macro: PUF_RELIAB_EN adds the abs_diff port and its subtractors.

module puf_cnt_cmp
  import puf_pkg::*;
#(
  parameter int CNT_W = PUF_CNT_W
) (
  input  logic [CNT_W-1:0] cnt_a,
  input  logic [CNT_W-1:0] cnt_b,
  output logic             gt
`ifdef PUF_RELIAB_EN
  ,
  output logic [CNT_W:0]   abs_diff
`endif
);

  assign gt = (cnt_a > cnt_b);

`ifdef PUF_RELIAB_EN
  // Both operands are zero-extended so the larger-minus-smaller subtraction
  // never wraps, even for 0 against the all-ones count.
  assign abs_diff = gt ? ({1'b0, cnt_a} - {1'b0, cnt_b})
                       : ({1'b0, cnt_b} - {1'b0, cnt_a});
`endif

endmodule

// File: rtl/puf_resp_packer.sv
// puf_resp_packer: packs RO-PUF comparison bits into RESP_W-bit response words.
//
// Parameters: CNT_W (count width), RESP_W (bits per word, 2..64),
//             MARGIN (counts; pairs this close are flagged as unreliable).
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   clr   - synchronous abort of any partial or held word
//   bus   - puf_resp_packer_if.slave (pair stream in, response word out)
//
// Each accepted pair writes resp[bit_idx] = (cnt_a > cnt_b). After RESP_W
// accepts the word is held with resp_valid high until the consumer takes it,
// then everything clears and collection restarts at bit 0.
//
// Macro: PUF_RELIAB_EN enables resp_mask / unstable_cnt; otherwise both are 0.

module puf_resp_packer
  import puf_pkg::*;
#(
  parameter int CNT_W  = PUF_CNT_W,
  parameter int RESP_W = PUF_RESP_W,
  parameter int MARGIN = 0
) (
  input logic              clk,
  input logic              rst_n,
  input logic              clr,
  puf_resp_packer_if.slave bus
);

  localparam int               IDX_W    = puf_w(RESP_W);
  localparam int               UC_W     = puf_w(RESP_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_W - 1);

  // MARGIN is compared against CNT_W-bit counts; a value outside that range
  // would be a configuration mistake, so it is rejected at elaboration.
  if ((MARGIN < 0) || (longint'(MARGIN) >= (longint'(1) << CNT_W))) begin : g_margin_range
    $error("puf_resp_packer: MARGIN does not fit in CNT_W bits");
  end

  puf_state_e        state_q, state_d;
  logic [IDX_W-1:0]  bit_idx_q;
  logic [RESP_W-1:0] resp_q;
  logic              gt;
  logic              accept;
  logic              last;
  logic              drop;

  // in_ready includes rst_n so nothing is accepted while reset is asserted.
  assign bus.in_ready   = (state_q == COLLECT) && rst_n;
  assign bus.resp_valid = (state_q == HOLD);
  assign bus.resp       = resp_q;
  assign bus.bit_idx    = bit_idx_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (bit_idx_q == LAST_IDX);
  // Abort and consumer handshake have the same effect on the datapath.
  assign drop   = clr || ((state_q == HOLD) && bus.resp_ready);

`ifdef PUF_RELIAB_EN
  logic [CNT_W:0] abs_diff;
`endif

  puf_cnt_cmp #(.CNT_W(CNT_W)) u_cmp (
    .cnt_a    (bus.cnt_a),
    .cnt_b    (bus.cnt_b),
    .gt       (gt)
`ifdef PUF_RELIAB_EN
    ,
    .abs_diff (abs_diff)
`endif
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // No HOLD->COLLECT bypass: a word taken this cycle lets in_ready rise next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (accept && last)  state_d = HOLD;
      HOLD:    if (bus.resp_ready) state_d = COLLECT;
      default:                     state_d = COLLECT;
    endcase
    if (clr) state_d = COLLECT;
  end

  // Response bits and index: slots above bit_idx remain 0 because every word
  // starts from a cleared register.
  always_ff @(posedge clk) begin
    if (!rst_n || drop) begin
      resp_q    <= '0;
      bit_idx_q <= '0;
    end else if (accept) begin
      resp_q[bit_idx_q] <= gt;
      bit_idx_q         <= last ? '0 : bit_idx_q + IDX_W'(1);
    end
  end

`ifdef PUF_RELIAB_EN
  logic [RESP_W-1:0] mask_q;
  logic [UC_W-1:0]   uc_q;
  logic              weak;

  assign weak = (abs_diff <= (CNT_W + 1)'(MARGIN));

  // unstable_cnt cannot exceed RESP_W since it rises at most once per slot.
  always_ff @(posedge clk) begin
    if (!rst_n || drop) begin
      mask_q <= '0;
      uc_q   <= '0;
    end else if (accept) begin
      mask_q[bit_idx_q] <= weak;
      if (weak) uc_q <= uc_q + UC_W'(1);
    end
  end

  assign bus.resp_mask    = mask_q;
  assign bus.unstable_cnt = uc_q;
`else
  assign bus.resp_mask    = '0;
  assign bus.unstable_cnt = '0;
`endif

endmodule
